uart_receive_eng: RTL

//  Serial-to-parallel UART receive engine; counterpart of the transmit engine on the far end of the line.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_receive_eng_if.sv | 29 ++
 rtl/uart_bit_timer.sv | 38 +++
 rtl/uart_receive_eng.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-rate table, counter width default, receive FSM
// state encoding and frame sizing. Used by both the receive and transmit engines.
package uart_pkg;

    // Widest bit-time counter needed for the slowest baud code (333333 clocks)
    localparam int CNT_W_DEFAULT = 19;

    // Most bits sampled after the start bit: 8 data + parity + stop
    localparam int SHIFT_W = 10;

    // Receive FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_DONE  = 2'd3
    } rx_state_t;

    // Bit time in system clocks for each 4-bit baud code; codes 12-15 alias the slowest rate
    function automatic logic [CNT_W_DEFAULT-1:0] baud_count(input logic [3:0] code);
        case (code)
            4'd0:    return 19'd333333;
            4'd1:    return 19'd83333;
            4'd2:    return 19'd41667;
            4'd3:    return 19'd20833;
            4'd4:    return 19'd10417;
            4'd5:    return 19'd5208;
            4'd6:    return 19'd2604;
            4'd7:    return 19'd1736;
            4'd8:    return 19'd868;
            4'd9:    return 19'd434;
            4'd10:   return 19'd217;
            4'd11:   return 19'd109;
            default: return 19'd333333;
        endcase
    endfunction

endpackage

// File: rtl/uart_receive_eng_if.sv
// Host-side bundle of the UART receive engine: serial line, framing
// configuration, the received byte with its status flags and the READ strobe.
interface uart_receive_eng_if;

    logic       rx;
    logic [3:0] baud;
    logic       eight;
    logic       parity_en;
    logic       odd_n_even;
    logic       read;
    logic [7:0] uart_data;
    logic       rxrdy;
    logic       perr;
    logic       ferr;
    logic       ovf;

    // Host / line side: drives the line and configuration, consumes the byte
    modport master (
        output rx, baud, eight, parity_en, odd_n_even, read,
        input  uart_data, rxrdy, perr, ferr, ovf
    );

    // Receive engine side
    modport slave (
        input  rx, baud, eight, parity_en, odd_n_even, read,
        output uart_data, rxrdy, perr, ferr, ovf
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-time generator shared by the UART engines. While i_run is high it counts
// clocks and emits a one-cycle o_tick after half a bit time (i_half_sel=1) or a
// full bit time (i_half_sel=0), then restarts. Dropping i_run clears the count.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_baud,
    input  logic       i_run,
    input  logic       i_half_sel,
    output logic       o_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_full;
    logic [CNT_W-1:0] w_target;

    // Select the terminal count: full bit time or half of it for the mid-start sample
    always_comb begin
        w_full   = CNT_W'(baud_count(i_baud));
        w_target = i_half_sel ? (w_full >> 1) : w_full;
    end

    assign o_tick = i_run && (r_cnt == (w_target - CNT_W'(1)));

    // Free-running count while enabled, restarting at the terminal value
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_run || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_receive_eng.sv
// UART receive engine. The serial line is synchronized, a start bit is confirmed
// at mid-bit, then data, optional parity and stop bits are sampled once per bit
// time into a shift register. A one-cycle DONE state commits the byte and status
// flags to the host registers, which hold until the host pulses READ.
module uart_receive_eng
    import uart_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEFAULT,
    parameter int SYNC_DEPTH = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    uart_receive_eng_if.slave  bus
);

    // Synchronizer and FSM
    logic [SYNC_DEPTH-1:0] r_sync;
    logic                  w_rx_s;
    rx_state_t             r_state;
    rx_state_t             w_next_state;

    // Timer control
    logic                  w_run;
    logic                  w_half_sel;
    logic                  w_tick;

    // Sampling datapath
    logic [SHIFT_W-1:0]    r_shift;
    logic [3:0]            r_bit_cnt;
    logic [3:0]            w_num_samples;
    logic                  w_sample;
    logic                  w_clear_bits;
    logic                  w_commit;
    logic [SHIFT_W-1:0]    w_aligned;
    logic [7:0]            w_data;
    logic                  w_parity_bit;
    logic                  w_stop_bit;
    logic                  w_perr;

    // Host-visible registers
    logic [7:0]            r_data;
    logic                  r_rxrdy;
    logic                  r_perr;
    logic                  r_ferr;
    logic                  r_ovf;

    assign w_rx_s = r_sync[SYNC_DEPTH-1];

    // Bits sampled after the start bit: data bits, optional parity, stop
    assign w_num_samples = (bus.eight ? 4'd8 : 4'd7) + {3'b000, bus.parity_en} + 4'd1;

    uart_bit_timer #(
        .CNT_W (CNT_W)
    ) u_bit_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_baud     (bus.baud),
        .i_run      (w_run),
        .i_half_sel (w_half_sel),
        .o_tick     (w_tick)
    );

    // Metastability synchronizer; loads idle-high so reset never fakes a start edge
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], bus.rx};
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control decode; the timer only runs in START and DATA, so
    // every state change either drops run or coincides with a terminal tick
    always_comb begin
        w_next_state = r_state;
        w_run        = 1'b0;
        w_half_sel   = 1'b0;
        w_sample     = 1'b0;
        w_clear_bits = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                w_run      = 1'b1;
                w_half_sel = 1'b1;
                if (w_tick) begin
                    if (w_rx_s) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_DATA;
                        w_clear_bits = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                w_run = 1'b1;
                if (w_tick) begin
                    w_sample = 1'b1;
                    if (r_bit_cnt == (w_num_samples - 4'd1)) begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_commit     = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Shift samples in from the top (LSB arrives first) and count them
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_clear_bits) begin
            r_bit_cnt <= '0;
        end else if (w_sample) begin
            r_shift   <= {w_rx_s, r_shift[SHIFT_W-1:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
        end
    end

    // Right-justify the frame so data starts at bit 0 whatever the frame length
    always_comb begin
        w_aligned    = r_shift >> (4'(SHIFT_W) - w_num_samples);
        w_data       = bus.eight ? w_aligned[7:0] : {1'b0, w_aligned[6:0]};
        w_parity_bit = bus.eight ? w_aligned[8] : w_aligned[7];
        w_stop_bit   = r_shift[SHIFT_W-1];
        w_perr       = bus.parity_en & (^w_data ^ w_parity_bit ^ bus.odd_n_even);
    end

    // Host registers: a commit always beats a READ in the same cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data  <= '0;
            r_rxrdy <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_commit) begin
            r_data  <= w_data;
            r_perr  <= w_perr;
            r_ferr  <= ~w_stop_bit;
            r_ovf   <= r_rxrdy;
            r_rxrdy <= 1'b1;
        end else if (bus.read && r_rxrdy) begin
            r_rxrdy <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
        end
    end

    assign bus.uart_data = r_data;
    assign bus.rxrdy     = r_rxrdy;
    assign bus.perr      = r_perr;
    assign bus.ferr      = r_ferr;
    assign bus.ovf       = r_ovf;

endmodule
